nd_bb_updown_counter: RTL and testbench
=======================================

// Module: nd_bb_updown_counter
//
// PURPOSE
//  Parametrised DIGITS-digit, base-BASE up/down counter, one DW-bit digit field per digit.
//  Generalises the fixed 4-digit base-10 cascade:
//   - direction control;
//   - synchronous clear and parallel load with digit validation;
//   - wrap or saturate mode;
//   - sticky overflow flag.
//  Cascadable through ei/eu. Used as event/time counter feeding decimal displays.
//
// PARAMETERS
//  DIGITS    4   number of digits (>=1)
//  BASE      10  radix of every digit (2..2**DW)
//  DW        4   bit width of one digit field
//  SATURATE  0   0 = wrap at terminal value, 1 = hold at terminal value
//
// PORTS
//  clock     in   1          single clock, all state updates on posedge
//  reset     in   1          asynchronous, active-high reset
//  ei        in   1          count enable (one step per cycle while high)
//  up        in   1          1 = increment, 0 = decrement; sampled with ei
//  clr       in   1          synchronous clear to all-zero
//  ld        in   1          synchronous parallel load of d
//  d         in   DIGITS*DW  load value, digit i in d[i*DW +: DW] (digit 0 = LSD)
//  q         out  DIGITS*DW  count value, same digit layout as d
//  eu        out  1          combinational carry/borrow out for cascading
//  ovf       out  1          sticky: a wrap or saturation event has occurred
//  ld_err    out  1          registered one-cycle pulse: load contained digit >= BASE
//
// BEHAVIOUR
//  - reset (async, any time): q=0, ovf=0, ld_err=0 immediately; eu follows combinationally.
//  - Priority at posedge: clr > ld > ei. Without clr, ld or ei, q holds.
//  - clr: q=0, ovf=0, ld_err=0 on next edge.
//  - ld: q takes d.
//    - Any digit of d >= BASE is stored as 0 instead.
//    - ld_err=1 for exactly the following cycle; otherwise ld_err=0.
//    - ovf cleared.
//  - Terminal value T:
//    - up=1: every digit == BASE-1.
//    - up=0: every digit == 0.
//  - Counting (ei=1, no clr/ld):
//    - Digit i steps when all digits below i are at their terminal digit
//      (BASE-1 for up, 0 for down).
//    - Up: BASE-1 -> 0 with carry; down: 0 -> BASE-1 with borrow.
//    - Digits never hold values >= BASE after reset/clr/ld.
//  - eu = ei & ~clr & ~ld & (q == T for current up). Asserted in the same cycle as ei
//    (zero latency), so one eu can drive the ei of a chained instance.
//  - At terminal with ei=1:
//    - SATURATE=0: q wraps (all-max -> 0 up, 0 -> all-max down).
//    - SATURATE=1: q holds.
//    - In both modes eu=1 and ovf is set at that edge.
//  - ovf stays 1 until reset, clr or ld.
//  - up changing between cycles takes effect on the next counting edge;
//    there is no hidden direction state.
//  - DIGITS=1 degenerates to a single base-BASE digit with the same rules.
//
// TESTING  (DIGITS=4, BASE=10, DW=4 unless stated)
//  1. Assert reset mid-count at q=0x0123, asynchronously to clock
//     -> q=0x0000, ovf=0, ld_err=0 before the next posedge.
//  2. ld d=0x0999, then ei=1, up=1 for 2 cycles
//     -> q=0x1000 then 0x1001; eu=0 throughout.
//  3. ld d=0x9999, ei=1, up=1
//     - SATURATE=0: eu=1 in that cycle, next q=0x0000, ovf=1.
//     - SATURATE=1: q stays 0x9999, eu=1, ovf=1.
//  4. From q=0x0000, ei=1, up=0
//     - SATURATE=0: eu=1, q -> 0x9999, ovf=1.
//     - Then 2 more down steps -> 0x9998, 0x9997.
//  5. ld d=0x12F4 -> q=0x1204; ld_err high for exactly one cycle;
//     clr+ld+ei in the same cycle -> q=0x0000.
//  6. Two instances chained (eu->ei), ei=1, up=1 for 10000 cycles from 0
//     -> low q=0x0000, high q=0x0001, low ovf=1.

Source files
------------

// File: rtl/nd_bb_updown_counter.sv
// Multi-digit base-BASE up/down counter with clear, validated parallel load,
// wrap/saturate selection, sticky overflow and a zero-latency cascade output.
module nd_bb_updown_counter #(
    parameter int DIGITS   = 4,
    parameter int BASE     = 10,
    parameter int DW       = 4,
    parameter int SATURATE = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ei,
    input  logic                 up,
    input  logic                 clr,
    input  logic                 ld,
    input  logic [DIGITS*DW-1:0] d,
    output logic [DIGITS*DW-1:0] q,
    output logic                 eu,
    output logic                 ovf,
    output logic                 ld_err
);

    localparam logic [DW-1:0] MAX_DIGIT = DW'(BASE - 1);
    localparam logic [DW:0]   BASE_EXT  = (DW + 1)'(BASE);

    logic [DIGITS*DW-1:0] q_d, q_q;
    logic                 ovf_d, ovf_q;
    logic                 ld_err_d, ld_err_q;

    logic [DW-1:0]        term_digit;
    logic                 at_term;
    logic [DIGITS*DW-1:0] step_val;
    logic                 carry;
    logic [DW-1:0]        cur_digit;
    logic [DIGITS*DW-1:0] load_val;
    logic                 load_bad;
    logic [DW-1:0]        in_digit;

    assign term_digit = up ? MAX_DIGIT : '0;

    always_comb begin
        at_term = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (q_q[i*DW +: DW] != term_digit) begin
                at_term = 1'b0;
            end
        end
    end

    // Ripple the step through the digits: a digit moves only while every
    // lower digit sits at its terminal value for the current direction.
    always_comb begin
        step_val  = q_q;
        carry     = 1'b1;
        cur_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            cur_digit = q_q[i*DW +: DW];
            if (carry) begin
                if (up) begin
                    step_val[i*DW +: DW] = (cur_digit == MAX_DIGIT) ? '0 : cur_digit + 1'b1;
                end else begin
                    step_val[i*DW +: DW] = (cur_digit == '0) ? MAX_DIGIT : cur_digit - 1'b1;
                end
            end
            carry = carry & (cur_digit == term_digit);
        end
    end

    always_comb begin
        load_val = '0;
        load_bad = 1'b0;
        in_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            in_digit = d[i*DW +: DW];
            if ({1'b0, in_digit} >= BASE_EXT) begin
                load_bad = 1'b1;
            end else begin
                load_val[i*DW +: DW] = in_digit;
            end
        end
    end

    always_comb begin
        q_d      = q_q;
        ovf_d    = ovf_q;
        ld_err_d = 1'b0;
        if (clr) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (ld) begin
            q_d      = load_val;
            ovf_d    = 1'b0;
            ld_err_d = load_bad;
        end else if (ei) begin
            if (at_term) begin
                ovf_d = 1'b1;
                if (SATURATE == 0) begin
                    q_d = step_val;
                end
            end else begin
                q_d = step_val;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q      <= '0;
            ovf_q    <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            ovf_q    <= ovf_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign q      = q_q;
    assign ovf    = ovf_q;
    assign ld_err = ld_err_q;
    assign eu     = ei & ~clr & ~ld & at_term;

endmodule

// File: tb/tb_nd_bb_updown_counter.sv
// Bench for nd_bb_updown_counter: wrap and saturate instances side by side,
// a vector table, async reset and cascade sequences, and a random phase.
module tb_nd_bb_updown_counter;

    localparam int MAXV = 9999;

    typedef struct {
        logic        ei, up, clr, ld;
        logic [15:0] d;
        logic        eu0, eu1;
        logic [15:0] q0, q1;
        logic        ovf0, ovf1, lderr;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ei = 1'b0, up = 1'b0, clr = 1'b0, ld = 1'b0;
    logic [15:0] d = '0;
    logic [15:0] q0, q1;
    logic        eu0, eu1, ovf0, ovf1, lderr0, lderr1;

    logic        c_ei = 1'b0;
    logic [15:0] lo_q, hi_q;
    logic        lo_eu, hi_eu, lo_ovf, hi_ovf, lo_lderr, hi_lderr;

    int          checks = 0;
    int          passed = 0;
    int          mval[2];
    bit          movf[2];
    bit          mlderr[2];
    logic        eu0_s, eu1_s, xeu0, xeu1;
    vec_t        vecs[16];

    always #5 clock = ~clock;

    nd_bb_updown_counter #(.DIGITS(4), .BASE(10), .DW(4), .SATURATE(0)) dut_wrap (
        .clock(clock), .reset(reset), .ei(ei), .up(up), .clr(clr), .ld(ld), .d(d),
        .q(q0), .eu(eu0), .ovf(ovf0), .ld_err(lderr0));

    nd_bb_updown_counter #(.DIGITS(4), .BASE(10), .DW(4), .SATURATE(1)) dut_sat (
        .clock(clock), .reset(reset), .ei(ei), .up(up), .clr(clr), .ld(ld), .d(d),
        .q(q1), .eu(eu1), .ovf(ovf1), .ld_err(lderr1));

    nd_bb_updown_counter #(.DIGITS(4), .BASE(10), .DW(4), .SATURATE(0)) chain_lo (
        .clock(clock), .reset(reset), .ei(c_ei), .up(1'b1), .clr(1'b0), .ld(1'b0), .d(16'h0000),
        .q(lo_q), .eu(lo_eu), .ovf(lo_ovf), .ld_err(lo_lderr));

    nd_bb_updown_counter #(.DIGITS(4), .BASE(10), .DW(4), .SATURATE(0)) chain_hi (
        .clock(clock), .reset(reset), .ei(lo_eu), .up(1'b1), .clr(1'b0), .ld(1'b0), .d(16'h0000),
        .q(hi_q), .eu(hi_eu), .ovf(hi_ovf), .ld_err(hi_lderr));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int load_value(input logic [15:0] x);
        int v = 0;
        int w = 1;
        for (int i = 0; i < 4; i++) begin
            if (x[i*4 +: 4] < 4'd10) v += int'(x[i*4 +: 4]) * w;
            w *= 10;
        end
        return v;
    endfunction

    function automatic bit load_bad(input logic [15:0] x);
        bit b = 0;
        for (int i = 0; i < 4; i++) if (x[i*4 +: 4] >= 4'd10) b = 1;
        return b;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic e, u, c, l, input logic [15:0] dd,
                                input logic xe0, xe1, input logic [15:0] xq0, xq1,
                                input logic xo0, xo1, xl);
        vec_t v;
        v.ei = e; v.up = u; v.clr = c; v.ld = l; v.d = dd;
        v.eu0 = xe0; v.eu1 = xe1; v.q0 = xq0; v.q1 = xq1;
        v.ovf0 = xo0; v.ovf1 = xo1; v.lderr = xl;
        return v;
    endfunction

    function automatic logic model_eu(input int k, input logic e, u, c, l);
        return e && !c && !l && (u ? (mval[k] == MAXV) : (mval[k] == 0));
    endfunction

    // Reference counter kept as a plain integer 0..9999; index 1 saturates.
    task automatic model_edge(input logic e, u, c, l, input logic [15:0] dd);
        for (int k = 0; k < 2; k++) begin
            mlderr[k] = 0;
            if (c) begin
                mval[k] = 0; movf[k] = 0;
            end else if (l) begin
                mval[k] = load_value(dd); movf[k] = 0; mlderr[k] = load_bad(dd);
            end else if (e) begin
                if (u && mval[k] == MAXV) begin
                    movf[k] = 1;
                    if (k == 0) mval[k] = 0;
                end else if (!u && mval[k] == 0) begin
                    movf[k] = 1;
                    if (k == 0) mval[k] = MAXV;
                end else begin
                    mval[k] = u ? mval[k] + 1 : mval[k] - 1;
                end
            end
        end
    endtask

    task automatic apply_stimulus(input logic e, u, c, l, input logic [15:0] dd);
        @(negedge clock);
        ei = e; up = u; clr = c; ld = l; d = dd;
        #1;
        eu0_s = eu0; eu1_s = eu1;
        xeu0 = model_eu(0, e, u, c, l);
        xeu1 = model_eu(1, e, u, c, l);
        @(posedge clock);
        model_edge(e, u, c, l, dd);
        #1;
    endtask

    task automatic check_output();
        check("eu_wrap", 32'(eu0_s), 32'(xeu0));
        check("eu_sat", 32'(eu1_s), 32'(xeu1));
        check("q_wrap", 32'(q0), 32'(to_bcd(mval[0])));
        check("q_sat", 32'(q1), 32'(to_bcd(mval[1])));
        check("ovf_wrap", 32'(ovf0), 32'(movf[0]));
        check("ovf_sat", 32'(ovf1), 32'(movf[1]));
        check("lderr_wrap", 32'(lderr0), 32'(mlderr[0]));
        check("lderr_sat", 32'(lderr1), 32'(mlderr[1]));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        e, u, c, l;
        logic [15:0] dd;
        int          r;

        mval[0] = 0; mval[1] = 0;
        movf[0] = 0; movf[1] = 0;
        mlderr[0] = 0; mlderr[1] = 0;

        vecs[0]  = mk(0, 1, 0, 1, 16'h0999, 0, 0, 16'h0999, 16'h0999, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h1000, 16'h1000, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h1001, 16'h1001, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 16'h0000, 0, 0, 16'h1001, 16'h1001, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 1, 16'h9999, 0, 0, 16'h9999, 16'h9999, 0, 0, 0);
        vecs[5]  = mk(1, 1, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h9999, 1, 1, 0);
        vecs[6]  = mk(1, 0, 0, 0, 16'h0000, 1, 0, 16'h9999, 16'h9998, 1, 1, 0);
        vecs[7]  = mk(1, 0, 0, 0, 16'h0000, 0, 0, 16'h9998, 16'h9997, 1, 1, 0);
        vecs[8]  = mk(1, 0, 0, 0, 16'h0000, 0, 0, 16'h9997, 16'h9996, 1, 1, 0);
        vecs[9]  = mk(0, 0, 0, 1, 16'h12F4, 0, 0, 16'h1204, 16'h1204, 0, 0, 1);
        vecs[10] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h1204, 16'h1204, 0, 0, 0);
        vecs[11] = mk(1, 1, 1, 1, 16'h5555, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[12] = mk(1, 0, 0, 0, 16'h0000, 1, 1, 16'h9999, 16'h0000, 1, 1, 0);
        vecs[13] = mk(1, 1, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[14] = mk(0, 1, 0, 1, 16'hA9B9, 0, 0, 16'h0909, 16'h0909, 0, 0, 1);
        vecs[15] = mk(0, 1, 0, 1, 16'h0999, 0, 0, 16'h0999, 16'h0999, 0, 0, 0);

        repeat (2) @(negedge clock);
        check("reset_q", 32'(q0), 32'h0);
        check("reset_ovf", 32'(ovf0), 32'h0);
        check("reset_lderr", 32'(lderr0), 32'h0);
        check("reset_eu_up", 32'(eu0), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i].ei, vecs[i].up, vecs[i].clr, vecs[i].ld, vecs[i].d);
            check($sformatf("vec%0d_eu_wrap", i), 32'(eu0_s), 32'(vecs[i].eu0));
            check($sformatf("vec%0d_eu_sat", i), 32'(eu1_s), 32'(vecs[i].eu1));
            check($sformatf("vec%0d_q_wrap", i), 32'(q0), 32'(vecs[i].q0));
            check($sformatf("vec%0d_q_sat", i), 32'(q1), 32'(vecs[i].q1));
            check($sformatf("vec%0d_ovf_wrap", i), 32'(ovf0), 32'(vecs[i].ovf0));
            check($sformatf("vec%0d_ovf_sat", i), 32'(ovf1), 32'(vecs[i].ovf1));
            check($sformatf("vec%0d_lderr", i), 32'(lderr0), 32'(vecs[i].lderr));
        end

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 31);
            c = (r == 0);
            l = (r < 5);
            e = ($urandom_range(0, 7) != 0);
            u = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: dd = 16'($urandom);
                1: dd = 16'h9999;
                2: dd = 16'h0000;
                default: dd = to_bcd($urandom_range(0, MAXV));
            endcase
            apply_stimulus(e, u, c, l, dd);
            check_output();
        end

        // Wrap to zero with ovf set, count to 0123, then reset between edges.
        apply_stimulus(0, 1, 0, 1, 16'h9999);
        apply_stimulus(1, 1, 0, 0, 16'h0000);
        for (int n = 0; n < 123; n++) apply_stimulus(1, 1, 0, 0, 16'h0000);
        check("pre_reset_q", 32'(q0), 32'h0123);
        check("pre_reset_ovf", 32'(ovf0), 32'h1);
        #3;
        ei = 1'b0; ld = 1'b0; clr = 1'b0;
        reset = 1'b1;
        #1;
        check("async_reset_q", 32'(q0), 32'h0);
        check("async_reset_ovf", 32'(ovf0), 32'h0);
        check("async_reset_lderr", 32'(lderr0), 32'h0);
        check("async_reset_q_sat", 32'(q1), 32'h0);
        check("async_reset_ovf_sat", 32'(ovf1), 32'h0);
        mval[0] = 0; mval[1] = 0;
        movf[0] = 0; movf[1] = 0;
        mlderr[0] = 0; mlderr[1] = 0;
        @(negedge clock);
        reset = 1'b0;

        @(negedge clock);
        c_ei = 1'b1;
        repeat (10000) @(posedge clock);
        @(negedge clock);
        c_ei = 1'b0;
        check("chain_lo_q", 32'(lo_q), 32'h0000);
        check("chain_hi_q", 32'(hi_q), 32'h0001);
        check("chain_lo_ovf", 32'(lo_ovf), 32'h1);
        check("chain_hi_ovf", 32'(hi_ovf), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
